// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One result bit per cycle: shift-add multiply, restoring divide. The latency is fixed at
// WIDTH + 1 edges from accept to valid_o, with no early-out.
// Ports:
//   clk_i, reset_n_i    clock, synchronous active-low reset
//   valid_i / ready_o   request handshake (ready_o = idle)
//   op_i                RV32M funct3 (MUL..REMU)
//   in1_i, in2_i        rs1 / rs2 operands
//   kill_i              flush: drop in-flight or unaccepted result
//   valid_o / ready_i   result handshake (valid_o = done)
//   out_o               result, held while valid_o = 1
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // Multiplicand for multiplies, divisor for divides.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     in1_q, in1_d;
  logic                 neg_q, neg_d;
  logic                 div0_q, div0_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     out_q, out_d;

  // Accept-time operand decode
  logic             in1_signed, in2_signed;
  logic             sign1, sign2;
  logic [WIDTH-1:0] abs1, abs2;

  always_comb begin
    in1_signed = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    in2_signed = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    sign1      = in1_signed & in1_i[WIDTH-1];
    sign2      = in2_signed & in2_i[WIDTH-1];
    abs1       = sign1 ? -in1_i : in1_i;
    abs2       = sign2 ? -in2_i : in2_i;
  end

  // One iteration step for each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_new;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    // rem_sh < 2 * divisor, so WIDTH+1 bits hold the signed difference.
    rem_diff = rem_sh - {1'b0, opnd_q};
    borrow   = rem_diff[WIDTH];
    rem_new  = borrow ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
  end

  // Result selection with sign fix-up
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   result;

  always_comb begin
    // High-half results need the full-width negation to propagate the borrow correctly.
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    result   = '0;
    if (!op_q[2]) begin
      result = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else if (div0_q) begin
      result = op_q[1] ? in1_q : '1;
    end else if (ovf_q) begin
      result = op_q[1] ? '0 : in1_q;
    end else begin
      result = op_q[1] ? rem_fix : quo_fix;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    in1_d   = in1_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          op_d   = op_i;
          cnt_d  = '0;
          in1_d  = in1_i;
          opnd_d = op_i[2] ? abs2 : abs1;
          acc_d  = {{WIDTH{1'b0}}, op_i[2] ? abs1 : abs2};
          // REM takes the dividend's sign; MUL*, DIV take the product of signs.
          neg_d  = (op_i[2] & op_i[1]) ? sign1 : (sign1 ^ sign2);
          div0_d = (in2_i == '0);
          ovf_d  = (op_i == 3'b100 || op_i == 3'b110) &&
                   (in1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (in2_i == '1);
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          acc_d = {rem_new, acc_q[WIDTH-2:0], ~borrow};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastStep) begin
          state_d = StSign;
        end
      end
      StSign: begin
        out_d   = result;
        state_d = StDone;
      end
      StDone: begin
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush wins over everything but reset; the last result stays on out_o.
    if (kill_i) begin
      state_d = StIdle;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      op_q    <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      in1_q   <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      in1_q   <= in1_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      out_q   <= out_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign out_o   = out_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M operation set for the execute stage. It runs beside the single-cycle ALU and handles operations the ALU cannot complete in one cycle. A valid/ready handshake on input and output lets the pipeline stall while an operation is in flight. Operand width is a parameter, so the same block serves narrower datapaths.

## Interface

Parameters:

- WIDTH, 32, operand/result width in bits; legal values ≥ 2.

Ports:

- clk_i  input  1  clock; all state changes on the rising edge.
- reset_n_i  input  1  synchronous, active-low reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request; equals (state == IDLE).
- op_i  input  3  operation, encoded as RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in1_i  input  WIDTH  rs1 operand (multiplicand / dividend).
- in2_i  input  WIDTH  rs2 operand (multiplier / divisor).
- kill_i  input  1  pipeline flush; abandons any in-flight or completed-but-unaccepted operation.
- valid_o  output  1  result valid; equals (state == DONE).
- ready_i  input  1  consumer accepts result.
- out_o  output  WIDTH  result; stable while valid_o = 1.

## Operation

- States: IDLE, CALC, SIGN, DONE.
- **Accept** happens when valid_i & ready_o & !kill_i.
  - Latch op_i.
  - Record signed-ness per operand:
    - in1 is signed for MULH, MULHSU, DIV, REM.
    - in2 is signed for MULH, DIV, REM.
  - Latch the absolute value of each signed operand.
  - Latch the negate flag:
    - multiply: sign(in1) ^ sign(in2).
    - DIV: sign(in1) ^ sign(in2).
    - REM: sign(in1).
  - Clear the step counter; go to CALC.
- **CALC** runs exactly WIDTH cycles, one bit per cycle.
  - Multiply (shift-add): 2·WIDTH-bit product register; each step conditionally adds the multiplicand into the upper half, then shifts right by 1.
  - Divide (restoring): WIDTH+1-bit partial remainder; each step shifts in the next dividend MSB, trial-subtracts the divisor, and keeps the difference when it is non-negative; the quotient bit is set to !borrow.
  - After step WIDTH-1, go to SIGN.
- **SIGN** (1 cycle) selects the result field and applies two's-complement negation when the negate flag is set:
  - MUL: low product half.
  - MULH*: high product half; the negation is applied to the full 2·WIDTH product before the high half is selected.
  - DIV*: quotient. REM*: remainder.
  - Special cases override the computed value:
    - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give in1 unchanged.
    - Signed overflow (in1 = 1 followed by WIDTH-1 zeros, in2 = all-ones, DIV/REM): DIV gives in1; REM gives 0.
  - Register out_o; go to DONE.
- **DONE**: hold out_o and valid_o until ready_i = 1, then go to IDLE.
- **kill_i** = 1 in any state: go to IDLE on the next edge; valid_o is 0 from that edge. kill_i also blocks a coincident accept. out_o keeps its value.
- **Priority**: reset_n_i > kill_i > normal transitions.

## Timing

- **Reset** (reset_n_i = 0 at an edge):
  - state = IDLE, so ready_o = 1 and valid_o = 0.
  - out_o = 0; counter = 0.
  - Reset during CALC, SIGN or DONE discards the operation.
- **Latency**: accept at edge E; valid_o rises at edge E + WIDTH + 1 (WIDTH CALC cycles plus 1 SIGN cycle).
  - Fixed for all ops, including divide-by-zero and overflow; no early-out.
- **Initiation interval**: the result is accepted at edge D; ready_o = 1 from D; the next request can be accepted at D+1. Minimum initiation interval is WIDTH + 3 cycles.
- **Combinational paths**: ready_o and valid_o depend only on state, never on valid_i or ready_i.
- **Input stability**: op_i, in1_i and in2_i are sampled only at the accept edge; later changes have no effect.
- **Back-pressure**: ready_i = 0 in DONE holds the result indefinitely, unchanged.

## Test plan

- **Multiply, WIDTH=32**:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
  - Each: valid_o first asserts exactly 33 edges after accept.
- **Divide signs**:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 % 2 → 1.
- **Special cases**:
  - DIV 5 / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
- **Handshake**:
  - Hold ready_i = 0 for 10 cycles in DONE → out_o and valid_o stable.
  - Change in1_i/in2_i during CALC → result unaffected.
  - Assert ready_i → ready_o = 1 on the next cycle; back-to-back requests complete correctly.
- **Flush and reset**:
  - kill_i mid-CALC → IDLE next edge, no valid_o.
  - kill_i together with valid_i in IDLE → no accept.
  - reset_n_i = 0 in DONE → valid_o = 0, out_o = 0, ready_o = 1.
- **Parameter sweep, WIDTH=8**:
  - Random ops vs. reference model over 10k vectors.
  - Latency is 9 edges.
